mem_arbiter: RTL and testbench

- Shares one word-wide backing-memory port between two line-granular requesters: instruction-cache refill (I, read-only) and data-cache refill/writeback (D, read or write).
- Sits between the cache blocks of the pipelined core and main memory.
- Grants one requester per burst and sequences BEATS word transfers over a valid/ready memory handshake.
- Returns the assembled line with a one-cycle done pulse to the granted requester.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the two-requester line-burst memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } arbStateT;

    typedef enum logic {
        OWN_I,
        OWN_D
    } ownerT;

    // Width of the beat index within one line burst.
    function automatic int unsigned beatIdxW(input int unsigned beats);
        return unsigned'($clog2(beats));
    endfunction

    // Number of byte-offset bits below a line base address.
    function automatic int unsigned lineOffW(input int unsigned beats, input int unsigned dataW);
        return unsigned'($clog2(beats * dataW / 8));
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-owner pointer is held by the caller.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic  iReq,
    input  logic  dReq,
    input  ownerT lastOwner,
    output logic  grantValid_c,
    output ownerT grantOwner_c
);

    always_comb begin
        grantValid_c = iReq | dReq;
        grantOwner_c = OWN_I;
        if (iReq && dReq) begin
            grantOwner_c = (lastOwner == OWN_I) ? OWN_D : OWN_I;
        end else if (dReq) begin
            grantOwner_c = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory port between I-cache refills and D-cache refills/writebacks,
// moving one whole line per grant as a burst of word beats.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_W-1:0]       i_addr,
    output logic [BEATS*DATA_W-1:0] i_rdata,
    output logic                    i_done,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_W-1:0]       d_addr,
    input  logic [BEATS*DATA_W-1:0] d_wdata,
    output logic [BEATS*DATA_W-1:0] d_rdata,
    output logic                    d_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ready,
    output logic                    busy
);

    localparam int unsigned BEAT_IDX_W = beatIdxW(BEATS);
    localparam int unsigned LINE_OFF_W = lineOffW(BEATS, DATA_W);
    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    typedef logic [BEATS-1:0][DATA_W-1:0] lineT;

    arbStateT              state, stateNext;
    ownerT                 owner, ownerNext, lastOwner, lastOwnerNext, grantOwner;
    logic                  grantValid;
    logic [BEAT_IDX_W-1:0] beat, beatNext;
    logic                  isWrite, isWriteNext;
    lineT                  wline, wlineNext, lineBuf, lineBufNext, dWords;
    logic                  memReqNext, memWeNext, iDoneNext, dDoneNext, busyNext;
    logic [ADDR_W-1:0]     memAddrNext, grantBase;
    logic [DATA_W-1:0]     memWdataNext;
    logic                  unusedAddrLow;

    assign dWords        = d_wdata;
    assign i_rdata       = lineBuf;
    assign d_rdata       = lineBuf;
    assign unusedAddrLow = ^{i_addr[LINE_OFF_W-1:0], d_addr[LINE_OFF_W-1:0]};

    rr_arb2 uArb (
        .iReq         (i_req),
        .dReq         (d_req),
        .lastOwner    (lastOwner),
        .grantValid_c (grantValid),
        .grantOwner_c (grantOwner)
    );

    // Line base of the winner; byte offset within the line is never forwarded.
    assign grantBase = (grantOwner == OWN_D)
        ? {d_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}}
        : {i_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

    // Next-state and next-output logic; every output is the register of its *Next value.
    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        lastOwnerNext = lastOwner;
        beatNext      = beat;
        isWriteNext   = isWrite;
        wlineNext     = wline;
        lineBufNext   = lineBuf;
        memReqNext    = mem_req;
        memWeNext     = mem_we;
        memAddrNext   = mem_addr;
        memWdataNext  = mem_wdata;
        iDoneNext     = 1'b0;
        dDoneNext     = 1'b0;
        busyNext      = busy;

        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    stateNext    = XFER;
                    ownerNext    = grantOwner;
                    beatNext     = '0;
                    isWriteNext  = (grantOwner == OWN_D) && d_we;
                    wlineNext    = (grantOwner == OWN_D) ? dWords : '0;
                    memReqNext   = 1'b1;
                    memWeNext    = isWriteNext;
                    memAddrNext  = grantBase;
                    memWdataNext = wlineNext[0];
                    busyNext     = 1'b1;
                end
            end
            XFER: begin
                if (mem_ready) begin
                    if (!isWrite) begin
                        lineBufNext[beat] = mem_rdata;
                    end
                    if (beat == LAST_BEAT) begin
                        stateNext    = DONE;
                        memReqNext   = 1'b0;
                        memWeNext    = 1'b0;
                        memAddrNext  = '0;
                        memWdataNext = '0;
                        iDoneNext    = (owner == OWN_I);
                        dDoneNext    = (owner == OWN_D);
                    end else begin
                        beatNext     = beat + BEAT_IDX_W'(1);
                        memAddrNext  = mem_addr + ADDR_W'(WORD_BYTES);
                        memWdataNext = wline[beatNext];
                    end
                end
            end
            DONE: begin
                stateNext     = IDLE;
                lastOwnerNext = owner;
                beatNext      = '0;
                busyNext      = 1'b0;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            lastOwner <= OWN_I;
            beat      <= '0;
            isWrite   <= 1'b0;
            wline     <= '0;
            lineBuf   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastOwner <= lastOwnerNext;
            beat      <= beatNext;
            isWrite   <= isWriteNext;
            wline     <= wlineNext;
            lineBuf   <= lineBufNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            i_done    <= iDoneNext;
            d_done    <= dDoneNext;
            busy      <= busyNext;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with hand-computed literals, then randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned BEATS      = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LINE_W     = BEATS * DATA_W;
    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int unsigned LINE_BYTES = LINE_W / 8;

    logic              clk;
    logic              rst;
    logic              i_req, d_req, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
    logic              i_done, d_done;
    logic              mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;
    logic [DATA_W-1:0] rdSalt;

    int errors = 0;
    int checks = 0;
    bit cmpEn  = 1'b0;

    mem_arbiter #(.BEATS(BEATS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word derived from the beat address.
    assign mem_rdata = mem_addr ^ rdSalt;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one burst at a time ----------------
    bit                mXfer, mDone, mOwnerD, mWe, mLastD;
    logic [1:0]        mBeat;
    logic [ADDR_W-1:0] mBase;
    logic [DATA_W-1:0] mWords [BEATS];
    logic [DATA_W-1:0] mBuf   [BEATS];
    logic              pickD;

    assign pickD = d_req && (!i_req || !mLastD);

    function automatic logic [ADDR_W-1:0] beatAddr(input logic [1:0] k);
        return mBase + ADDR_W'(k) * ADDR_W'(WORD_BYTES);
    endfunction

    function automatic logic [LINE_W-1:0] packBuf();
        logic [LINE_W-1:0] v;
        v = '0;
        for (int k = 0; k < BEATS; k++) v[k*DATA_W +: DATA_W] = mBuf[k];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mXfer <= 1'b0; mDone <= 1'b0; mOwnerD <= 1'b0; mWe <= 1'b0; mLastD <= 1'b0;
            mBeat <= '0; mBase <= '0;
            for (int k = 0; k < BEATS; k++) mBuf[k] <= '0;
        end else if (mDone) begin
            mDone  <= 1'b0;
            mLastD <= mOwnerD;
        end else if (mXfer) begin
            if (mem_ready) begin
                if (!mWe) mBuf[mBeat] <= beatAddr(mBeat) ^ rdSalt;
                if (mBeat == 2'(BEATS - 1)) begin
                    mXfer <= 1'b0;
                    mDone <= 1'b1;
                end else begin
                    mBeat <= mBeat + 2'd1;
                end
            end
        end else if (i_req || d_req) begin
            mOwnerD <= pickD;
            mWe     <= pickD && d_we;
            mBase   <= (pickD ? d_addr : i_addr) & ~ADDR_W'(LINE_BYTES - 1);
            for (int k = 0; k < BEATS; k++) mWords[k] <= d_wdata[k*DATA_W +: DATA_W];
            mXfer   <= 1'b1;
            mBeat   <= '0;
        end
    end

    // Compare every cycle, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            check("mem_req", LINE_W'(mem_req), LINE_W'(mXfer));
            check("busy",    LINE_W'(busy),    LINE_W'(mXfer || mDone));
            check("i_done",  LINE_W'(i_done),  LINE_W'(mDone && !mOwnerD));
            check("d_done",  LINE_W'(d_done),  LINE_W'(mDone && mOwnerD));
            check("i_rdata", i_rdata, packBuf());
            check("d_rdata", d_rdata, packBuf());
            if (mXfer) begin
                check("mem_we",   LINE_W'(mem_we),   LINE_W'(mWe));
                check("mem_addr", LINE_W'(mem_addr), LINE_W'(beatAddr(mBeat)));
                if (mWe) check("mem_wdata", LINE_W'(mem_wdata), LINE_W'(mWords[mBeat]));
            end
            if (!rst) begin
                check("rst_mem_we",    LINE_W'(mem_we),    '0);
                check("rst_mem_addr",  LINE_W'(mem_addr),  '0);
                check("rst_mem_wdata", LINE_W'(mem_wdata), '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [ADDR_W-1:0] seenAddr [4];
    logic [DATA_W-1:0] seenData [4];
    int nBeat, doneCyc, dDones, nOrder, dStartCyc;
    int order [4];
    bit allWe;

    initial begin
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; rdSalt = '0;
        step();
        cmpEn = 1'b1;
        check("reset_mem_req", LINE_W'(mem_req), '0);
        check("reset_busy",    LINE_W'(busy),    '0);
        check("reset_rdata",   i_rdata,          '0);
        doReset();

        // Single I read, memory returns its own address.
        mem_ready = 1'b1; i_req = 1'b1; i_addr = 32'h0000_1008;
        nBeat = 0; doneCyc = 0; dDones = 0;
        for (int c = 2; c <= 12; c++) begin
            step();
            if (mem_req && nBeat < 4) begin seenAddr[nBeat] = mem_addr; nBeat++; end
            if (i_done) begin doneCyc = c; i_req = 1'b0; end
            if (d_done) dDones++;
        end
        check("t1_beats", LINE_W'(nBeat), LINE_W'(4));
        check("t1_addr0", LINE_W'(seenAddr[0]), LINE_W'(32'h1000));
        check("t1_addr1", LINE_W'(seenAddr[1]), LINE_W'(32'h1004));
        check("t1_addr2", LINE_W'(seenAddr[2]), LINE_W'(32'h1008));
        check("t1_addr3", LINE_W'(seenAddr[3]), LINE_W'(32'h100C));
        check("t1_done_cycle", LINE_W'(doneCyc), LINE_W'(6));
        check("t1_no_d_done", LINE_W'(dDones), '0);
        check("t1_line", i_rdata, 128'h0000100C_00001008_00001004_00001000);

        // D writeback with mem_ready on alternate cycles.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000;
        d_wdata = 128'h00000004_00000003_00000002_00000001; mem_ready = 1'b0;
        nBeat = 0; dDones = 0; allWe = 1'b1;
        for (int c = 2; c <= 20; c++) begin
            step();
            mem_ready = 1'((c % 2) == 1);
            if (mem_req && mem_ready && nBeat < 4) begin
                seenAddr[nBeat] = mem_addr; seenData[nBeat] = mem_wdata;
                allWe = allWe && mem_we; nBeat++;
            end
            if (d_done) begin dDones++; d_req = 1'b0; end
        end
        check("t2_beats", LINE_W'(nBeat), LINE_W'(4));
        check("t2_we", LINE_W'(allWe), LINE_W'(1));
        for (int k = 0; k < 4; k++) begin
            check("t2_addr", LINE_W'(seenAddr[k]), LINE_W'(32'h2000 + 4 * k));
            check("t2_data", LINE_W'(seenData[k]), LINE_W'(k + 1));
        end
        check("t2_d_done_once", LINE_W'(dDones), LINE_W'(1));
        check("t2_buf_kept", d_rdata, 128'h0000100C_00001008_00001004_00001000);

        // Simultaneous requests after reset, both held: D, I, D, I.
        doReset();
        mem_ready = 1'b1; d_we = 1'b0;
        i_req = 1'b1; i_addr = 32'h3000; d_req = 1'b1; d_addr = 32'h4000;
        nOrder = 0;
        for (int c = 2; c <= 40; c++) begin
            step();
            if ((i_done || d_done) && nOrder < 4) begin order[nOrder] = int'(d_done); nOrder++; end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("t3_count", LINE_W'(nOrder), LINE_W'(4));
        check("t3_g0_d", LINE_W'(order[0]), LINE_W'(1));
        check("t3_g1_i", LINE_W'(order[1]), LINE_W'(0));
        check("t3_g2_d", LINE_W'(order[2]), LINE_W'(1));
        check("t3_g3_i", LINE_W'(order[3]), LINE_W'(0));

        // D requests continuously; I asks once mid-burst and is not starved.
        doReset();
        mem_ready = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        nOrder = 0;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (c == 3) begin i_req = 1'b1; i_addr = 32'h6040; end
            if ((i_done || d_done) && nOrder < 3) begin order[nOrder] = int'(d_done); nOrder++; end
            if (i_done) i_req = 1'b0;
        end
        d_req = 1'b0;
        check("t4_count", LINE_W'(nOrder), LINE_W'(3));
        check("t4_first_d", LINE_W'(order[0]), LINE_W'(1));
        check("t4_then_i", LINE_W'(order[1]), LINE_W'(0));
        check("t4_back_d", LINE_W'(order[2]), LINE_W'(1));

        // Reset pulled low during beat 2 of an I read.
        doReset();
        rdSalt = 32'hDEAD_0000; mem_ready = 1'b1; i_req = 1'b1; i_addr = 32'h7000;
        step(); step(); step();
        check("t5_beat2_addr", LINE_W'(mem_addr), LINE_W'(32'h7008));
        #2;
        rst = 1'b0; i_req = 1'b0;
        #1;
        check("t5_async_mem_req", LINE_W'(mem_req), '0);
        check("t5_async_busy", LINE_W'(busy), '0);
        check("t5_async_rdata", i_rdata, '0);
        dDones = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (i_done || d_done) dDones++;
        end
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h7010;
        doneCyc = 0;
        for (int c = 2; c <= 12; c++) begin
            step();
            if (i_done || d_done) begin
                if (doneCyc == 0 && i_done) begin
                    doneCyc = c;
                    check("t5_fresh_line", i_rdata, 128'hDEAD701C_DEAD7018_DEAD7014_DEAD7010);
                end
                i_req = 1'b0;
            end
        end
        check("t5_no_done_in_reset", LINE_W'(dDones), '0);
        check("t5_fresh_done_cycle", LINE_W'(doneCyc), LINE_W'(6));

        // I drops and D rises mid-burst: I finishes, D granted in next IDLE cycle.
        doReset();
        rdSalt = '0; mem_ready = 1'b1; i_req = 1'b1; i_addr = 32'h8004;
        doneCyc = 0; dStartCyc = 0;
        for (int c = 2; c <= 20; c++) begin
            step();
            if (c == 3) begin i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h9000; end
            if (i_done && doneCyc == 0) begin
                doneCyc = c;
                check("t6_i_line", i_rdata, 128'h0000800C_00008008_00008004_00008000);
            end
            if (mem_req && mem_addr == 32'h9000 && dStartCyc == 0) dStartCyc = c;
            if (d_done) d_req = 1'b0;
        end
        check("t6_i_done_cycle", LINE_W'(doneCyc), LINE_W'(6));
        check("t6_d_first_beat", LINE_W'(dStartCyc), LINE_W'(8));

        // Randomized traffic checked by the model.
        doReset();
        rdSalt = $urandom();
        for (int c = 0; c < 3000; c++) begin
            step();
            mem_ready = ($urandom_range(0, 9) < 7);
            if (i_done) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = $urandom();
            end else if (!i_req) begin
                if ($urandom_range(0, 3) == 0) begin i_req = 1'b1; i_addr = $urandom(); end
            end else if ($urandom_range(0, 49) == 0) begin
                i_req = 1'b0;
            end
            if (d_done) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else begin d_addr = $urandom(); d_we = 1'($urandom_range(0, 1)); end
            end else if (!d_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    d_req = 1'b1; d_addr = $urandom(); d_we = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 49) == 0) begin
                d_req = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 799) == 0) begin
                #2;
                rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
                step();
                rst = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
